// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // mult/multu/div/divu all have op[2] clear; they are the ops that occupy the unit.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: result is computed at launch and
// committed after a fixed number of busy cycles.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stallReq,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e       state, next_state;
  logic [CW-1:0]    cnt, load_val;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             accept, launch, commit;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe, a_mag, b_mag, q_mag, r_mag, q_u, r_u;
  logic               a_neg, b_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (launch) next_state = ST_RUN;
      ST_RUN:  if (cnt == CW'(1)) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_RUN);
    accept   = (state == ST_IDLE) && start;
    launch   = accept && is_muldiv(MDUOp);
    commit   = busy && (cnt == CW'(1));
    stallReq = busy | (start & is_muldiv(MDUOp));
  end

  // Single-cycle result logic; an iterative divider could replace this block.
  // A zero divisor is swapped for 1 so the datapath never produces X; its result is discarded.
  always_comb begin
    prod_s   = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    b_safe   = (B == '0) ? WIDTH'(1) : B;
    a_neg    = A[WIDTH-1];
    b_neg    = b_safe[WIDTH-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -b_safe : b_safe;
    q_mag    = a_mag / b_mag;
    r_mag    = a_mag % b_mag;
    q_u      = A / b_safe;
    r_u      = A % b_safe;
    load_val = MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    res_hi   = HI;
    res_lo   = LO;
    case (mdu_op_e'(MDUOp))
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: if (B != '0) begin
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
      end
      MDU_DIVU: if (B != '0) begin
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      if (launch) begin
        cnt     <= load_val;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
      if (accept && (MDUOp == MDU_MTHI)) HI <= A;
      if (accept && (MDUOp == MDU_MTLO)) LO <= A;
    end
  end

endmodule
